// File: rtl/ball_serve_ctrl.sv
// Serve controller: folds the LFSR word into a legal start row, counts down, launches the ball,
// and tracks lives / game-over. Optional auto-serve after idle time via `AUTO_SERVE_EN.
module ball_serve_ctrl #(
  parameter int Y_MIN       = 40,
  parameter int Y_MAX       = 439,
  parameter int SERVE_DELAY = 60,
  parameter int START_LIVES = 3,
  parameter int AUTO_DELAY  = 300
) (
  input  logic       gameclk,
  input  logic       resetn,
  input  logic [9:0] rnd_in,
  input  logic       serve_btn,
  input  logic       ball_lost,
  input  logic       brick_clear,
  output logic [9:0] ball_y0,
  output logic       ball_dir_up,
  output logic       ball_launch,
  output logic       ball_active,
  output logic [2:0] lives,
  output logic       game_over
);

  localparam int SPAN = Y_MAX - Y_MIN + 1;
  localparam logic [9:0] SPAN_V  = 10'(SPAN);
  localparam logic [9:0] Y_MIN_V = 10'(Y_MIN);
  localparam int CW = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;
  localparam logic [CW-1:0] CD_LOAD = CW'(SERVE_DELAY - 1);
  localparam logic [2:0] LIVES_INIT = 3'(START_LIVES);

  if (SPAN < 1 || SPAN > 512) begin : g_bad_span
    $error("ball_serve_ctrl: Y_MAX-Y_MIN+1 must be in 1..512");
  end
  if (SERVE_DELAY < 1 || AUTO_DELAY < 1) begin : g_bad_delay
    $error("ball_serve_ctrl: SERVE_DELAY and AUTO_DELAY must be >= 1");
  end
  if (START_LIVES < 1 || START_LIVES > 7) begin : g_bad_lives
    $error("ball_serve_ctrl: START_LIVES must be in 1..7");
  end

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_PLAY, S_OVER} state_t;

  state_t          r_state;
  logic            r_btn_q;
  logic [CW-1:0]   r_cnt;
  logic [9:0]      r_row;
  logic            r_dir;
  logic [9:0]      r_y0;
  logic            r_dir_up;
  logic            r_launch;
  logic            r_active;
  logic [2:0]      r_lives;
  logic            r_over;

  logic            w_srv;
  logic            w_auto;
  logic            w_take;
  logic [9:0]      w_off_raw;
  logic [9:0]      w_off_sub;
  logic [9:0]      w_off;
  logic [9:0]      w_row;

  assign w_srv = serve_btn & ~r_btn_q;

  // A single conditional subtract covers 0..511; the clamp only matters when SPAN < 256.
  always_comb begin
    w_off_raw = {1'b0, rnd_in[8:0]};
    w_off_sub = w_off_raw;
    if (w_off_raw >= SPAN_V) w_off_sub = w_off_raw - SPAN_V;
    w_off = w_off_sub;
    if (w_off_sub >= SPAN_V) w_off = SPAN_V - 10'd1;
    w_row = Y_MIN_V + w_off;
  end

`ifdef AUTO_SERVE_EN
  localparam int AW = (AUTO_DELAY > 1) ? $clog2(AUTO_DELAY) : 1;
  localparam logic [AW-1:0] AUTO_LAST = AW'(AUTO_DELAY - 1);
  logic [AW-1:0] r_idle_cnt;

  assign w_auto = (r_idle_cnt == AUTO_LAST);

  // Zero outside IDLE, so the count always starts fresh on entry.
  always_ff @(posedge gameclk) begin
    if (!resetn) begin
      r_idle_cnt <= '0;
    end else if (r_state == S_IDLE && !w_take) begin
      r_idle_cnt <= r_idle_cnt + AW'(1);
    end else begin
      r_idle_cnt <= '0;
    end
  end
`else
  assign w_auto = 1'b0;
`endif

  assign w_take = w_srv | w_auto;

  always_ff @(posedge gameclk) begin
    if (!resetn) begin
      r_state  <= S_IDLE;
      r_btn_q  <= 1'b0;
      r_cnt    <= '0;
      r_row    <= Y_MIN_V;
      r_dir    <= 1'b0;
      r_y0     <= Y_MIN_V;
      r_dir_up <= 1'b0;
      r_launch <= 1'b0;
      r_active <= 1'b0;
      r_lives  <= LIVES_INIT;
      r_over   <= 1'b0;
    end else begin
      r_btn_q  <= serve_btn;
      r_launch <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_take) begin
            r_row   <= w_row;
            r_dir   <= rnd_in[9];
            r_cnt   <= CD_LOAD;
            r_state <= S_ARM;
          end
        end
        S_ARM: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
          end else begin
            r_y0     <= r_row;
            r_dir_up <= r_dir;
            r_launch <= 1'b1;
            r_active <= 1'b1;
            r_state  <= S_PLAY;
          end
        end
        S_PLAY: begin
          if (brick_clear) begin
            r_active <= 1'b0;
            r_state  <= S_IDLE;
          end else if (ball_lost) begin
            r_active <= 1'b0;
            if (r_lives == 3'd1) begin
              r_lives <= 3'd0;
              r_over  <= 1'b1;
              r_state <= S_OVER;
            end else begin
              r_lives <= r_lives - 3'd1;
              r_state <= S_IDLE;
            end
          end
        end
        S_OVER: begin
          // Restart only; the serve needs a fresh edge after returning to IDLE.
          if (w_srv) begin
            r_lives <= LIVES_INIT;
            r_over  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ball_y0     = r_y0;
  assign ball_dir_up = r_dir_up;
  assign ball_launch = r_launch;
  assign ball_active = r_active;
  assign lives       = r_lives;
  assign game_over   = r_over;

endmodule

// File: doc/ball_serve_ctrl.md
Name: ball_serve_ctrl

Overview:
Downstream consumer of the LFSR random y-location stage. Samples the 10-bit pseudo-random word on a serve request and folds it into a legal playfield row. Runs a serve countdown, then launches the ball with a registered start row and vertical direction. Tracks lives, round restarts and game-over for the ball/paddle logic.

Parameters:
Y_MIN, 40, lowest legal ball start row (inclusive)
Y_MAX, 439, highest legal ball start row (inclusive); SPAN = Y_MAX-Y_MIN+1, 1 <= SPAN <= 512
SERVE_DELAY, 60, gameclk cycles from accepted serve to launch, >= 1
START_LIVES, 3, lives loaded at reset and on restart, 1..7
AUTO_DELAY, 300, idle cycles before auto-serve (AUTO_SERVE_EN only), >= 1

Ports:
gameclk  in  1  game tick clock, all logic on rising edge
resetn  in  1  synchronous active-low reset
rnd_in  in  10  pseudo-random word from the LFSR stage
serve_btn  in  1  serve/restart button, already debounced, level
ball_lost  in  1  ball passed paddle, single-cycle pulse
brick_clear  in  1  all bricks destroyed, single-cycle pulse
ball_y0  out  10  start row for the ball, valid from ball_launch onward
ball_dir_up  out  1  1 = initial vertical motion upward
ball_launch  out  1  one-cycle pulse: load ball at ball_y0 and start moving
ball_active  out  1  ball in play
lives  out  3  remaining lives
game_over  out  1  high while in OVER state

Behaviour:
- Reset (resetn low at edge): state IDLE, ball_y0=Y_MIN, ball_dir_up=0, ball_launch=0, ball_active=0, lives=START_LIVES, game_over=0, countdown=0, btn_q=0. Reset wins over all inputs, incl. mid-countdown or in PLAY.
- Serve edge: srv = serve_btn & ~btn_q; btn_q <= serve_btn each cycle. Held button = one edge.
- Row fold (on capture): off = rnd_in[8:0]; if off >= SPAN then off = off - SPAN; if still >= SPAN then off = SPAN-1. row = Y_MIN + off. dir = rnd_in[9]. Stored in internal regs; rnd_in = 0 gives row Y_MIN, dir 0.
- IDLE: on srv -> capture row/dir, countdown <= SERVE_DELAY-1, go ARM. ball_lost/brick_clear ignored.
- ARM: countdown != 0 -> decrement. countdown == 0 -> next edge: ball_y0 <= row, ball_dir_up <= dir, ball_launch <= 1, ball_active <= 1, go PLAY. Launch edge is SERVE_DELAY edges after the capture edge. srv ignored in ARM.
- PLAY: ball_launch is low except the launch cycle. brick_clear -> ball_active <= 0, IDLE, lives unchanged. ball_lost (no brick_clear) -> ball_active <= 0; lives==1 -> lives <= 0, game_over <= 1, OVER; else lives <= lives-1, IDLE. Simultaneous brick_clear and ball_lost: brick_clear wins, no life lost. srv ignored.
- OVER: game_over=1, ball_active=0. srv -> lives <= START_LIVES, game_over <= 0, IDLE. The same press does not serve; a fresh edge is required.
- ball_y0 and ball_dir_up hold their last launched values outside the launch cycle.
- ball_y0 always lies in [Y_MIN, Y_MAX].

Optional Feature:
Macro AUTO_SERVE_EN. Defined: an idle counter runs in IDLE only and clears on entry to IDLE. If AUTO_DELAY consecutive IDLE cycles pass with no srv, it behaves exactly as srv on that cycle, capturing rnd_in then. It never fires in OVER. Undefined: no idle counter; only serve_btn serves. Port list is identical either way.

Test Plan:
- Reset/defaults: resetn=0 two cycles -> ball_y0=40, lives=3, ball_active=0, game_over=0, ball_launch=0.
- Serve timing (SERVE_DELAY=3): rnd_in=10'h27B at the serve edge. Here off=0x7B=123, row=163, dir=1. -> ball_launch high exactly one cycle, 3 edges after capture; ball_y0=163, ball_dir_up=1, ball_active=1.
- Fold bounds: rnd_in=10'h1FF -> off=511-400=111, ball_y0=151. rnd_in=10'h190 (400) -> ball_y0=40. rnd_in=10'h18F (399) -> ball_y0=439. Held serve_btn for 10 cycles -> only one launch.
- Lives/game over: from PLAY with lives=3, three ball_lost pulses, each followed by a serve. -> lives 2,1,0; game_over=1 after the third pulse. The next press -> lives=3, IDLE, no ball_launch.
- Simultaneous: ball_lost and brick_clear in the same PLAY cycle -> IDLE, lives unchanged, ball_active=0. ball_lost in IDLE -> no change. resetn=0 during ARM -> no launch, IDLE.
- AUTO_SERVE_EN (AUTO_DELAY=5, SERVE_DELAY=3): no press after reset -> auto capture on the 5th IDLE cycle, launch 3 edges later. Macro undefined -> no launch after 1000 cycles.
